// File: rtl/led_pwm_pkg.sv
// Shared types and defaults for the LED PWM current-sink controller.
// State enum, encoding width and default parameter values used by led_pwm_drv and led_pwm_chan.
package led_pwm_pkg;

    localparam int NCH_DEF    = 3;
    localparam int PWM_W_DEF  = 8;
    localparam int CUR_W_DEF  = 10;
    localparam int SETTLE_DEF = 16;
    localparam int STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Channel-select width that stays legal for a single-channel build.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: shadow/active duty and current registers, PWM comparator and gated leg mask.
// With LED_RAMP_EN defined, a per-channel ramp mask soft-starts the current legs.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int PWM_W = PWM_W_DEF,
    parameter int CUR_W = CUR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [PWM_W-1:0] cfg_duty,
    input  logic [CUR_W-1:0] cfg_cur,
    input  logic             period_start,
`ifdef LED_RAMP_EN
    input  logic             ramp_clr,
`endif
    input  logic             active,
    input  logic [PWM_W-1:0] cnt_next,
    output logic             led_pwm,
    output logic [CUR_W-1:0] led_cbit
);

    logic [PWM_W-1:0] duty_s_reg, duty_a_reg, duty_a_next;
    logic [CUR_W-1:0] cur_s_reg, cur_a_reg, cur_a_next;
    logic [CUR_W-1:0] cur_eff_next;
    logic             pwm_reg, pwm_next;
    logic [CUR_W-1:0] cbit_reg;

    // A write landing on the period-start edge forwards straight into the active copy.
    assign duty_a_next = period_start ? (cfg_wr ? cfg_duty : duty_s_reg) : duty_a_reg;
    assign cur_a_next  = period_start ? (cfg_wr ? cfg_cur  : cur_s_reg)  : cur_a_reg;
    assign pwm_next    = active && (cnt_next < duty_a_next);

`ifdef LED_RAMP_EN
    logic [CUR_W-1:0] rm_reg, rm_next, rm_shift;

    generate
        if (CUR_W > 1) begin : g_shift
            assign rm_shift = {rm_reg[CUR_W-2:0], 1'b1};
        end else begin : g_shift1
            assign rm_shift = 1'b1;
        end
    endgenerate

    assign rm_next      = ramp_clr ? '0 : (period_start ? rm_shift : rm_reg);
    assign cur_eff_next = cur_a_next & rm_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rm_reg <= '0;
        end else begin
            rm_reg <= rm_next;
        end
    end
`else
    assign cur_eff_next = cur_a_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_s_reg <= '0;
            cur_s_reg  <= '0;
            duty_a_reg <= '0;
            cur_a_reg  <= '0;
            pwm_reg    <= 1'b0;
            cbit_reg   <= '0;
        end else begin
            if (cfg_wr) begin
                duty_s_reg <= cfg_duty;
                cur_s_reg  <= cfg_cur;
            end
            duty_a_reg <= duty_a_next;
            cur_a_reg  <= cur_a_next;
            pwm_reg    <= pwm_next;
            cbit_reg   <= pwm_next ? cur_eff_next : '0;
        end
    end

    assign led_pwm  = pwm_reg;
    assign led_cbit = cbit_reg;

endmodule

// File: rtl/led_pwm_drv.sv
// Multi-channel LED current-sink controller: bias sequencing FSM, settle and period counters.
// Optional soft-start ramp of current legs is enabled by defining LED_RAMP_EN.
module led_pwm_drv
    import led_pwm_pkg::*;
#(
    parameter  int NCH    = NCH_DEF,
    parameter  int PWM_W  = PWM_W_DEF,
    parameter  int CUR_W  = CUR_W_DEF,
    parameter  int SETTLE = SETTLE_DEF,
    localparam int CH_W   = ch_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 poc,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [PWM_W-1:0]     cfg_duty,
    input  logic [CUR_W-1:0]     cfg_cur,
    output logic                 bias_en,
    output logic [NCH-1:0]       led_pwm,
    output logic [NCH*CUR_W-1:0] led_cbit,
    output logic                 busy
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [PWM_W-1:0] CNT_MAX   = {{(PWM_W-1){1'b1}}, 1'b0};
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE - 1);

    state_t           state_reg, state_next;
    logic [PWM_W-1:0] cnt_reg, cnt_next;
    logic [SET_W-1:0] settle_reg, settle_next;
    logic             on_reg;
    logic             wrap, period_start, active;

    assign wrap   = (cnt_reg == CNT_MAX);
    assign active = (state_next == ST_RUN) || (state_next == ST_DRAIN);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        settle_next  = settle_reg;
        period_start = 1'b0;
        if (poc) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            settle_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cnt_next    = '0;
                    settle_next = '0;
                    if (en) state_next = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!en) begin
                        state_next  = ST_IDLE;
                        settle_next = '0;
                    end else if (settle_reg == SET_LAST) begin
                        state_next   = ST_RUN;
                        cnt_next     = '0;
                        settle_next  = '0;
                        period_start = 1'b1;
                    end else begin
                        settle_next = settle_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_next     = wrap ? '0 : cnt_reg + 1'b1;
                    period_start = wrap;
                    if (!en) state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    // The draining period finishes untouched; en decides only at the wrap.
                    cnt_next = wrap ? '0 : cnt_reg + 1'b1;
                    if (wrap) begin
                        if (en) begin
                            state_next   = ST_RUN;
                            period_start = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            settle_reg <= '0;
            on_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            settle_reg <= settle_next;
            on_reg     <= (state_next != ST_IDLE);
        end
    end

    assign bias_en = on_reg;
    assign busy    = on_reg;

`ifdef LED_RAMP_EN
    logic ramp_clr;
    assign ramp_clr = (state_reg == ST_IDLE) && (state_next == ST_SETTLE);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic cfg_wr;
            assign cfg_wr = cfg_we && (int'(cfg_ch) == gi);

            led_pwm_chan #(
                .PWM_W (PWM_W),
                .CUR_W (CUR_W)
            ) u_chan (
                .clk          (clk),
                .rst_n        (rst_n),
                .cfg_wr       (cfg_wr),
                .cfg_duty     (cfg_duty),
                .cfg_cur      (cfg_cur),
                .period_start (period_start),
`ifdef LED_RAMP_EN
                .ramp_clr     (ramp_clr),
`endif
                .active       (active),
                .cnt_next     (cnt_next),
                .led_pwm      (led_pwm[gi]),
                .led_cbit     (led_cbit[gi*CUR_W +: CUR_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_pwm_drv.sv
// Self-checking bench for led_pwm_drv: random configs checked against a timeline model.
// The model tracks when the run starts/stops and computes outputs from period position.
module tb_led_pwm_drv;

    localparam int NCH    = 3;
    localparam int PWM_W  = 8;
    localparam int CUR_W  = 10;
    localparam int SETTLE = 16;
    localparam int PERIOD = (1 << PWM_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 poc = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [1:0]           cfg_ch = '0;
    logic [PWM_W-1:0]     cfg_duty = '0;
    logic [CUR_W-1:0]     cfg_cur = '0;
    logic                 bias_en, busy;
    logic [NCH-1:0]       led_pwm;
    logic [NCH*CUR_W-1:0] led_cbit;

    always #5 clk = ~clk;

    led_pwm_drv #(
        .NCH    (NCH),
        .PWM_W  (PWM_W),
        .CUR_W  (CUR_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .poc      (poc),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_duty (cfg_duty),
        .cfg_cur  (cfg_cur),
        .bias_en  (bias_en),
        .led_pwm  (led_pwm),
        .led_cbit (led_cbit),
        .busy     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: edge index, when bias/run begin, when outputs stop.
    int edge_n      = 0;
    bit running     = 1'b0;
    int bias_origin = 0;
    int run_origin  = 0;
    int stop_edge   = -1;
    int period_idx  = 0;
    int pos         = -1;
    int sh_duty[NCH];
    int sh_cur[NCH];
    int ac_duty[NCH];
    int ac_cur[NCH];
    logic                 exp_bias;
    logic [NCH-1:0]       exp_pwm;
    logic [NCH*CUR_W-1:0] exp_cbit;

    function automatic logic [CUR_W-1:0] ramp_mask(input int p);
`ifdef LED_RAMP_EN
        if (p >= CUR_W) return '1;
        return CUR_W'((1 << p) - 1);
`else
        return '1;
`endif
    endfunction

    // Advance one clock and compute the expected outputs after that edge.
    task automatic tick();
        bit we;
        int ch, d, cu;
        bit live;
        we = cfg_we; ch = int'(cfg_ch); d = int'(cfg_duty); cu = int'(cfg_cur);
        @(posedge clk);
        #1;
        edge_n++;
        if (we && ch < NCH) begin
            sh_duty[ch] = d;
            sh_cur[ch]  = cu;
        end
        live     = running && (stop_edge < 0 || edge_n < stop_edge);
        exp_bias = live && (edge_n >= bias_origin);
        exp_pwm  = '0;
        exp_cbit = '0;
        pos      = -1;
        if (live && edge_n >= run_origin) begin
            pos = (edge_n - run_origin) % PERIOD;
            if (pos == 0) begin
                for (int c = 0; c < NCH; c++) begin
                    ac_duty[c] = sh_duty[c];
                    ac_cur[c]  = sh_cur[c];
                end
                period_idx++;
            end
            for (int c = 0; c < NCH; c++) begin
                if (pos < ac_duty[c]) begin
                    exp_pwm[c] = 1'b1;
                    exp_cbit[c*CUR_W +: CUR_W] = CUR_W'(ac_cur[c]) & ramp_mask(period_idx);
                end
            end
        end
    endtask

    // en is sampled at the next edge; SETTLE then RUN follow from that edge.
    task automatic start_run();
        en          = 1'b1;
        running     = 1'b1;
        stop_edge   = -1;
        bias_origin = edge_n + 1;
        run_origin  = edge_n + 1 + SETTLE;
        period_idx  = 0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < NCH; c++) begin
            sh_duty[c] = 0; sh_cur[c] = 0; ac_duty[c] = 0; ac_cur[c] = 0;
        end
        #12;
        n_tests++;
        if (bias_en !== 1'b0) begin n_fail++; $display("FAIL reset_bias: got %b want 0", bias_en); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++;
        if (led_pwm !== '0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", led_pwm); end
        n_tests++;
        if (led_cbit !== '0) begin n_fail++; $display("FAIL reset_cbit: got %h want 0", led_cbit); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({bias_en, busy, led_pwm} !== {exp_bias, exp_bias, exp_pwm} || led_cbit !== exp_cbit) begin
                n_fail++;
                $display("FAIL idle_quiet edge %0d: bias/busy/pwm %b%b%b cbit %h, want %b%b%b cbit %h",
                         edge_n, bias_en, busy, led_pwm, led_cbit, exp_bias, exp_bias, exp_pwm, exp_cbit);
            end
        end
    endtask

    task automatic test_settle_pwm();
        for (int c = 0; c <= NCH; c++) begin
            cfg_we   = 1'b1;
            cfg_ch   = 2'(c);
            cfg_duty = (c == 0) ? 8'd64 : 8'($urandom_range(1, 254));
            cfg_cur  = (c == 0) ? 10'h3FF : 10'($urandom_range(1, 1023));
            tick();
            n_tests++;
            if ({bias_en, busy, led_pwm} !== {exp_bias, exp_bias, exp_pwm} || led_cbit !== exp_cbit) begin
                n_fail++;
                $display("FAIL cfg_idle edge %0d: bias/busy/pwm %b%b%b cbit %h, want %b%b%b cbit %h",
                         edge_n, bias_en, busy, led_pwm, led_cbit, exp_bias, exp_bias, exp_pwm, exp_cbit);
            end
        end
        cfg_we = 1'b0;
        start_run();
        for (int i = 0; i < SETTLE + 2 * PERIOD + 5; i++) begin
            tick();
            n_tests++;
            if ({bias_en, busy, led_pwm} !== {exp_bias, exp_bias, exp_pwm} || led_cbit !== exp_cbit) begin
                n_fail++;
                $display("FAIL settle_pwm edge %0d pos %0d: bias/busy/pwm %b%b%b cbit %h, want %b%b%b cbit %h",
                         edge_n, pos, bias_en, busy, led_pwm, led_cbit, exp_bias, exp_bias, exp_pwm, exp_cbit);
            end
        end
    endtask

    task automatic test_duty_limits();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_duty = 8'd0;   cfg_cur = 10'($urandom_range(1, 1023));
        tick();
        cfg_ch = 2'd2; cfg_duty = 8'd255; cfg_cur = 10'($urandom_range(1, 1023));
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 3; i++) begin
            tick();
            n_tests++;
            if ({bias_en, busy, led_pwm} !== {exp_bias, exp_bias, exp_pwm} || led_cbit !== exp_cbit) begin
                n_fail++;
                $display("FAIL duty_limits edge %0d pos %0d: bias/busy/pwm %b%b%b cbit %h, want %b%b%b cbit %h",
                         edge_n, pos, bias_en, busy, led_pwm, led_cbit, exp_bias, exp_bias, exp_pwm, exp_cbit);
            end
        end
    endtask

    task automatic test_mid_write();
        int guard = 0;
        while (pos != 100 && guard < 2 * PERIOD) begin
            tick();
            guard++;
        end
        n_tests++;
        if (pos != 100) begin n_fail++; $display("FAIL mid_write_sync: pos %0d want 100", pos); end
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_duty = 8'd128; cfg_cur = 10'h3FF;
        tick();
        cfg_ch = 2'd1; cfg_duty = 8'($urandom_range(1, 254)); cfg_cur = 10'd0;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            n_tests++;
            if ({bias_en, busy, led_pwm} !== {exp_bias, exp_bias, exp_pwm} || led_cbit !== exp_cbit) begin
                n_fail++;
                $display("FAIL mid_write edge %0d pos %0d: bias/busy/pwm %b%b%b cbit %h, want %b%b%b cbit %h",
                         edge_n, pos, bias_en, busy, led_pwm, led_cbit, exp_bias, exp_bias, exp_pwm, exp_cbit);
            end
        end
    endtask

    task automatic test_drain();
        int guard = 0;
        while (pos != 100 && guard < 2 * PERIOD) begin tick(); guard++; end
        en = 1'b0;
        stop_edge = edge_n + (PERIOD - pos);
        for (int i = 0; i < PERIOD + 10; i++) begin
            tick();
            n_tests++;
            if ({bias_en, busy, led_pwm} !== {exp_bias, exp_bias, exp_pwm} || led_cbit !== exp_cbit) begin
                n_fail++;
                $display("FAIL drain_idle edge %0d pos %0d: bias/busy/pwm %b%b%b cbit %h, want %b%b%b cbit %h",
                         edge_n, pos, bias_en, busy, led_pwm, led_cbit, exp_bias, exp_bias, exp_pwm, exp_cbit);
            end
        end
        start_run();
        guard = 0;
        while (pos != 100 && guard < SETTLE + 2 * PERIOD) begin tick(); guard++; end
        en = 1'b0;
        guard = 0;
        while (pos != 200 && guard < PERIOD) begin tick(); guard++; end
        en = 1'b1;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            n_tests++;
            if ({bias_en, busy, led_pwm} !== {exp_bias, exp_bias, exp_pwm} || led_cbit !== exp_cbit) begin
                n_fail++;
                $display("FAIL drain_rerun edge %0d pos %0d: bias/busy/pwm %b%b%b cbit %h, want %b%b%b cbit %h",
                         edge_n, pos, bias_en, busy, led_pwm, led_cbit, exp_bias, exp_bias, exp_pwm, exp_cbit);
            end
        end
    endtask

    task automatic test_poc();
        int guard = 0;
        while (pos != 50 && guard < 2 * PERIOD) begin tick(); guard++; end
        poc = 1'b1;
        running = 1'b0;
        tick();
        n_tests++;
        if ({bias_en, busy, led_pwm} !== 5'b0 || led_cbit !== '0) begin
            n_fail++;
            $display("FAIL poc_clear edge %0d: bias/busy/pwm %b%b%b cbit %h, want all 0",
                     edge_n, bias_en, busy, led_pwm, led_cbit);
        end
        poc = 1'b0;
        start_run();
        for (int i = 0; i < SETTLE + PERIOD + 5; i++) begin
            tick();
            n_tests++;
            if ({bias_en, busy, led_pwm} !== {exp_bias, exp_bias, exp_pwm} || led_cbit !== exp_cbit) begin
                n_fail++;
                $display("FAIL poc_restart edge %0d pos %0d: bias/busy/pwm %b%b%b cbit %h, want %b%b%b cbit %h",
                         edge_n, pos, bias_en, busy, led_pwm, led_cbit, exp_bias, exp_bias, exp_pwm, exp_cbit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_settle_pwm();
        test_duty_limits();
        test_mid_write();
        test_drain();
        test_poc();
        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
